// File: rtl/simd_adder_pipe_pkg.sv
// Shared constants and types for the pipelined SIMD adder/subtractor.
package simd_adder_pipe_pkg;

  localparam int LEN_DATA = 64;
  localparam int LEN_LANE = 8;

  typedef enum logic [1:0] {
    ADD_OP_ADD  = 2'b00,
    ADD_OP_SUB  = 2'b01,
    ADD_OP_ADDI = 2'b10,
    ADD_OP_RSBI = 2'b11
  } add_op_e;

  // Both subtracting ops have op[0] set; the second operand is inverted.
  function automatic logic op_is_sub(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/simd_adder_pipe_if.sv
// Operand/result bus of the SIMD adder.
// Handshake: a beat moves on a rising edge only when valid and ready are both
// high in that cycle; a valid beat and its payload stay unchanged until taken,
// and ready may depend combinationally on the consumer side.
interface simd_adder_pipe_if #(
  parameter int DATA_W = 64,
  parameter int LANES  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] imm;
  logic [LANES-1:0]  cin;
  logic [LANES-1:0]  cmsk_n;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [LANES-1:0]  cout;
  logic [LANES-1:0]  ovf;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, op, a, b, imm, cin, cmsk_n, out_ready,
    input  in_ready, out_valid, result, cout, ovf
  );

  // The adder itself.
  modport slave (
    input  in_valid, op, a, b, imm, cin, cmsk_n, out_ready,
    output in_ready, out_valid, result, cout, ovf
  );
endinterface

// File: rtl/simd_adder_pipe_lane.sv
// One LANE_W-bit slice of the SIMD adder: purely combinational.
module simd_adder_lane #(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] i_x,
  input  logic [LANE_W-1:0] i_y,
  input  logic              i_sub,
  input  logic              i_cin_inj,
  input  logic              i_cmsk,
  input  logic              i_cprev,
  output logic [LANE_W-1:0] o_s,
  output logic              o_cout,
  output logic              o_ovf
);
  logic [LANE_W-1:0] w_y;
  logic              w_c;
  logic [LANE_W:0]   w_sum;
  logic              w_c_msb;

  // Subtraction is x + ~y + 1; the +1 comes from the injected carry at a base.
  assign w_y     = i_sub ? ~i_y : i_y;
  assign w_c     = i_cmsk ? i_cprev : (i_cin_inj ^ i_sub);
  assign w_sum   = {1'b0, i_x} + {1'b0, w_y} + {{LANE_W{1'b0}}, w_c};
  assign o_s     = w_sum[LANE_W-1:0];
  assign o_cout  = w_sum[LANE_W];
  // Carry into the MSB recovered from the MSB sum bit.
  assign w_c_msb = i_x[LANE_W-1] ^ w_y[LANE_W-1] ^ w_sum[LANE_W-1];
  assign o_ovf   = w_c_msb ^ w_sum[LANE_W];
endmodule

// File: rtl/simd_adder_pipe.sv
// Pipelined SIMD adder/subtractor. Stage k resolves lanes [k*LPS,(k+1)*LPS);
// the operands of unresolved lanes travel with the beat, and the carry out of
// a stage's top lane reaches the next stage through its registered cout field.
module simd_adder_pipe
  import simd_adder_pipe_pkg::*;
#(
  parameter int DATA_W = LEN_DATA,
  parameter int LANE_W = LEN_LANE,
  parameter int STAGES = 2
) (
  input logic             clk,
  input logic             rst_n,
  input logic             en,
  simd_adder_pipe_if.slave bus
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int LPS   = LANES / STAGES;

  logic              r_valid [STAGES];
  logic [DATA_W-1:0] r_x     [STAGES];
  logic [DATA_W-1:0] r_y     [STAGES];
  logic [DATA_W-1:0] r_res   [STAGES];
  logic              r_sub   [STAGES];
  logic [LANES-1:0]  r_cin   [STAGES];
  logic [LANES-1:0]  r_cmsk  [STAGES];
  logic [LANES-1:0]  r_cout  [STAGES];
  logic [LANES-1:0]  r_ovf   [STAGES];

  logic              w_src_valid [STAGES];
  logic [DATA_W-1:0] w_src_x     [STAGES];
  logic [DATA_W-1:0] w_src_y     [STAGES];
  logic [DATA_W-1:0] w_src_res   [STAGES];
  logic              w_src_sub   [STAGES];
  logic [LANES-1:0]  w_src_cin   [STAGES];
  logic [LANES-1:0]  w_src_cmsk  [STAGES];
  logic [LANES-1:0]  w_src_cout  [STAGES];
  logic [LANES-1:0]  w_src_ovf   [STAGES];

  logic [DATA_W-1:0] w_nxt_res  [STAGES];
  logic [LANES-1:0]  w_nxt_cout [STAGES];
  logic [LANES-1:0]  w_nxt_ovf  [STAGES];

  logic [DATA_W-1:0] w_in_x;
  logic [DATA_W-1:0] w_in_y;
  logic [DATA_W-1:0] w_lane_s;
  logic [LANES-1:0]  w_lane_cout;
  logic [LANES-1:0]  w_lane_ovf;
  logic              w_adv;

  // The whole pipeline moves together whenever the output slot can drain.
  assign w_adv        = en & (~bus.out_valid | bus.out_ready);
  assign bus.in_ready = w_adv & rst_n;

  // Operand select: (x, y) pair for each op.
  always_comb begin
    w_in_x = bus.a;
    w_in_y = bus.b;
    case (add_op_e'(bus.op))
      ADD_OP_ADD, ADD_OP_SUB: begin w_in_x = bus.a;   w_in_y = bus.b;   end
      ADD_OP_ADDI:            begin w_in_x = bus.a;   w_in_y = bus.imm; end
      ADD_OP_RSBI:            begin w_in_x = bus.imm; w_in_y = bus.a;   end
      default:                begin w_in_x = bus.a;   w_in_y = bus.b;   end
    endcase
  end

  // Stage 0 reads the input bus; later stages read the previous register.
  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      assign w_src_valid[k] = bus.in_valid;
      assign w_src_x[k]     = w_in_x;
      assign w_src_y[k]     = w_in_y;
      assign w_src_res[k]   = '0;
      assign w_src_sub[k]   = op_is_sub(bus.op);
      assign w_src_cin[k]   = bus.cin;
      assign w_src_cmsk[k]  = bus.cmsk_n;
      assign w_src_cout[k]  = '0;
      assign w_src_ovf[k]   = '0;
    end else begin : g_rest
      assign w_src_valid[k] = r_valid[k-1];
      assign w_src_x[k]     = r_x[k-1];
      assign w_src_y[k]     = r_y[k-1];
      assign w_src_res[k]   = r_res[k-1];
      assign w_src_sub[k]   = r_sub[k-1];
      assign w_src_cin[k]   = r_cin[k-1];
      assign w_src_cmsk[k]  = r_cmsk[k-1];
      assign w_src_cout[k]  = r_cout[k-1];
      assign w_src_ovf[k]   = r_ovf[k-1];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int S = i / LPS;
    logic w_cprev;
    // Lane 0 has no neighbour: feeding it its own injected carry makes
    // cmsk_n[0] irrelevant. Stage-base lanes take the registered carry.
    if (i == 0) begin : g_c0
      assign w_cprev = w_src_cin[S][0] ^ w_src_sub[S];
    end else if (i % LPS == 0) begin : g_creg
      assign w_cprev = w_src_cout[S][i-1];
    end else begin : g_cchain
      assign w_cprev = w_lane_cout[i-1];
    end

    simd_adder_lane #(.LANE_W(LANE_W)) u_lane (
      .i_x       (w_src_x[S][i*LANE_W +: LANE_W]),
      .i_y       (w_src_y[S][i*LANE_W +: LANE_W]),
      .i_sub     (w_src_sub[S]),
      .i_cin_inj (w_src_cin[S][i]),
      .i_cmsk    (w_src_cmsk[S][i]),
      .i_cprev   (w_cprev),
      .o_s       (w_lane_s[i*LANE_W +: LANE_W]),
      .o_cout    (w_lane_cout[i]),
      .o_ovf     (w_lane_ovf[i])
    );
  end

  // Merge this stage's freshly resolved lanes into the travelling result.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_nxt_res[k]  = w_src_res[k];
      w_nxt_cout[k] = w_src_cout[k];
      w_nxt_ovf[k]  = w_src_ovf[k];
      for (int j = 0; j < LPS; j++) begin
        w_nxt_res[k][(k*LPS+j)*LANE_W +: LANE_W] = w_lane_s[(k*LPS+j)*LANE_W +: LANE_W];
        w_nxt_cout[k][k*LPS+j] = w_lane_cout[k*LPS+j];
        w_nxt_ovf[k][k*LPS+j]  = w_lane_ovf[k*LPS+j];
      end
    end
  end

  // Pipeline registers: flush on reset, hold on stall, shift on advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_x[k]     <= '0;
        r_y[k]     <= '0;
        r_res[k]   <= '0;
        r_sub[k]   <= 1'b0;
        r_cin[k]   <= '0;
        r_cmsk[k]  <= '0;
        r_cout[k]  <= '0;
        r_ovf[k]   <= '0;
      end
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_src_valid[k];
        r_x[k]     <= w_src_x[k];
        r_y[k]     <= w_src_y[k];
        r_res[k]   <= w_nxt_res[k];
        r_sub[k]   <= w_src_sub[k];
        r_cin[k]   <= w_src_cin[k];
        r_cmsk[k]  <= w_src_cmsk[k];
        r_cout[k]  <= w_nxt_cout[k];
        r_ovf[k]   <= w_nxt_ovf[k];
      end
    end
  end

  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.result    = r_res[STAGES-1];
  assign bus.cout      = r_cout[STAGES-1];
  assign bus.ovf       = r_ovf[STAGES-1];
endmodule
